// File: rtl/coeff_scan_pkg.sv
// coeff_scan_pkg
// Shared constants and the scanner state type for the coefficient
// run/level scanner and its next-nonzero finder.
package coeff_scan_pkg;

    localparam int N     = 16;   // coefficients per 4x4 block
    localparam int IDX_W = 4;    // zigzag index width
    localparam int POS_W = 5;    // scan position / last_pos width (one extra bit)

    localparam logic [POS_W-1:0] LAST_NONE = 5'h1F;  // -1: no nonzero level

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/next_nz_finder.sv
// next_nz_finder
// Combinational masked lowest-set-bit priority encoder.
// Ports:
//   i_mask  - 16-bit nonzero mask
//   i_pos   - lowest position that may be returned
//   o_idx   - lowest set mask bit at or above i_pos (0 when none)
//   o_none  - no set bit at or above i_pos
module next_nz_finder
    import coeff_scan_pkg::*;
(
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_pos,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_none
);

    logic [N-1:0] w_masked;

    always_comb begin
        w_masked = i_mask & ({N{1'b1}} << i_pos);
        o_idx    = '0;
        // Walk downwards so the lowest set bit wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (w_masked[k]) o_idx = IDX_W'(k);
        end
        o_none = (w_masked == '0);
    end

endmodule

// File: rtl/coeff_run_scan.sv
// coeff_run_scan
// Captures one zigzag-ordered block of 16 quantized levels on start and
// emits every nonzero level as an (index, run, level, last) tuple over a
// valid/ready stream, one tuple per cycle when not backpressured.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, in, nz, first - block capture pulse, levels, block-nonzero flag,
//                          scan start index (1 = skip DC)
//   busy                - scan in progress
//   out_valid/out_ready - tuple handshake
//   out_idx, out_run, out_level, out_last - tuple fields
//   last_pos            - last nonzero position (5'h1F when none)
//   done                - one-cycle end-of-block pulse
module coeff_run_scan
    import coeff_scan_pkg::*;
#(
    parameter int BLOCK_SIZE = 4,
    parameter int LW         = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [LW*BLOCK_SIZE*BLOCK_SIZE-1:0]   in,
    input  logic                                  nz,
    input  logic                                  first,
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [IDX_W-1:0]                      out_idx,
    output logic [IDX_W-1:0]                      out_run,
    output logic signed [LW-1:0]                  out_level,
    output logic                                  out_last,
    output logic [POS_W-1:0]                      last_pos,
    output logic                                  done
);

    localparam int NB = BLOCK_SIZE * BLOCK_SIZE;

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [LW-1:0] r_level [NB];
    logic [N-1:0]         r_mask;
    logic [POS_W-1:0]     r_pos;
    logic [POS_W-1:0]     r_last_pos;
    logic                 r_out_valid;
    logic [IDX_W-1:0]     r_out_idx;
    logic [IDX_W-1:0]     r_out_run;
    logic signed [LW-1:0] r_out_level;
    logic                 r_out_last;

    logic [N-1:0]         w_cap_mask;
    logic [N-1:0]         w_cap_rev;
    logic [IDX_W-1:0]     w_found;
    logic                 w_none;
    logic [IDX_W-1:0]     w_rev_found;
    logic                 w_rev_none;
    logic [POS_W-1:0]     w_cap_last;
    logic                 w_none_eff;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_capture;

    // Mask of the incoming block: nonzero levels at or above first, all
    // cleared when the quantizer reports an all-zero block.
    always_comb begin
        w_cap_mask = '0;
        w_cap_rev  = '0;
        for (int k = 0; k < N; k++) begin
            w_cap_mask[k] = nz && (in[LW*k +: LW] != '0) && ((k != 0) || !first);
        end
        for (int k = 0; k < N; k++) begin
            w_cap_rev[k] = w_cap_mask[N-1-k];
        end
    end

    next_nz_finder u_next (
        .i_mask (r_mask),
        .i_pos  (r_pos[IDX_W-1:0]),
        .o_idx  (w_found),
        .o_none (w_none)
    );

    // Highest set bit of the capture mask = lowest set bit of its reversal.
    next_nz_finder u_last (
        .i_mask (w_cap_rev),
        .i_pos  ('0),
        .o_idx  (w_rev_found),
        .o_none (w_rev_none)
    );

    assign w_cap_last = w_rev_none ? LAST_NONE
                                   : {1'b0, 4'd15 - w_rev_found};

    // pos reaches 16 after emitting index 15; nothing is left to find then.
    assign w_none_eff = w_none || r_pos[POS_W-1];
    assign w_capture  = (r_state == IDLE) && start;
    assign w_accept   = r_out_valid && out_ready;
    assign w_load     = (r_state == SCAN) && !w_none_eff
                        && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = SCAN;
            SCAN: begin
                if (r_mask == '0)              w_state_nxt = FIN;
                else if (w_accept && r_out_last) w_state_nxt = FIN;
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SCAN);
        done = (r_state == FIN);
    end

    // Level storage is not reset: an empty mask already discards the block.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < NB; k++) r_level[k] <= in[LW*k +: LW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask      <= '0;
            r_pos       <= '0;
            r_last_pos  <= LAST_NONE;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_run   <= '0;
            r_out_level <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_mask     <= w_cap_mask;
                r_pos      <= {{(POS_W-1){1'b0}}, first};
                r_last_pos <= w_cap_last;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= w_found;
                r_out_run   <= w_found - r_pos[IDX_W-1:0];
                r_out_level <= r_level[w_found];
                r_out_last  <= (w_found == r_last_pos[IDX_W-1:0]);
                r_pos       <= {1'b0, w_found} + 5'd1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_run   = r_out_run;
    assign out_level = r_out_level;
    assign out_last  = r_out_last;
    assign last_pos  = r_last_pos;

endmodule

// File: tb/tb_coeff_run_scan.sv
// tb_coeff_run_scan
// Scoreboard bench: each block's expected tuples come from a list-based
// reference model and are queued; a negedge monitor pops them on every
// handshake and also checks that stalled tuples hold steady.
module tb_coeff_run_scan;

    localparam int LW = 16;
    localparam int N  = 16;

    typedef struct packed {
        logic [3:0]  idx;
        logic [3:0]  run;
        logic [15:0] level;
        logic        last;
    } tup_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LW*N-1:0]   in_bus = '0;
    logic              nz = 1'b0;
    logic              first = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              out_valid;
    logic [3:0]        out_idx;
    logic [3:0]        out_run;
    logic signed [15:0] out_level;
    logic              out_last;
    logic [4:0]        last_pos;
    logic              done;

    coeff_run_scan #(.BLOCK_SIZE(4), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in        (in_bus),
        .nz        (nz),
        .first     (first),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_run   (out_run),
        .out_level (out_level),
        .out_last  (out_last),
        .last_pos  (last_pos),
        .done      (done)
    );

    always #5 clk = ~clk;

    tup_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   stall_cnt = 0;
    logic prev_stall = 1'b0;
    tup_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic tup_t cur_tuple();
        tup_t t;
        t.idx   = out_idx;
        t.run   = out_run;
        t.level = out_level;
        t.last  = out_last;
        return t;
    endfunction

    // Monitor: tuple order, content and stall stability.
    always @(negedge clk) begin
        tup_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_tuple", cur_tuple(), held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_tuple: got %h expected none", cur_tuple());
                end else begin
                    e = exp_q.pop_front();
                    chk("tuple", cur_tuple(), e);
                end
            end
            if (out_valid && !out_ready) stall_cnt++;
            prev_stall = out_valid && !out_ready;
            held       = cur_tuple();
        end
    end

    function automatic logic ready_fn(input int mode, input int n);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            default: return !(n >= 3 && n <= 5);
        endcase
    endfunction

    // Runs one block. rst_at>0 asserts reset in that cycle after start.
    task automatic run_block(input logic [LW*N-1:0] lv, input logic bnz, input logic bfirst,
                             input int rmode, input bit glitch, input int rst_at);
        int   k_cnt;
        int   prev;
        int   lastp;
        bit   seen;
        logic [15:0] lvk;
        logic [4:0]  exp_last;
        tup_t t;
        k_cnt = 0;
        prev  = bfirst;
        lastp = -1;
        seen  = 0;
        for (int k = bfirst; k < N; k++) begin
            lvk = lv[k*LW +: LW];
            if (bnz && lvk != 0) begin
                t.idx   = 4'(k);
                t.run   = 4'(k - prev);
                t.level = lvk;
                t.last  = 1'b0;
                exp_q.push_back(t);
                prev  = k + 1;
                lastp = k;
                k_cnt++;
            end
        end
        if (k_cnt > 0) begin
            t = exp_q.pop_back();
            t.last = 1'b1;
            exp_q.push_back(t);
        end
        exp_last = (lastp < 0) ? 5'h1F : 5'(lastp);

        @(posedge clk); #1;
        in_bus    = lv;
        nz        = bnz;
        first     = bfirst;
        start     = 1'b1;
        out_ready = ready_fn(rmode, 0);
        stall_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            out_ready = ready_fn(rmode, n);
            start = glitch && (n == 5);
            if (start) in_bus = {8{$urandom()}};
            if (rst_at > 0 && n == rst_at)     rst = 1'b1;
            if (rst_at > 0 && n == rst_at + 2) rst = 1'b0;
            @(negedge clk);
            if (n == 1) begin
                chk("busy_T1", {31'b0, busy}, 32'd1);
                chk("last_pos", {27'b0, last_pos}, {27'b0, exp_last});
            end
            if (rst_at > 0 && n >= rst_at) begin
                chk("rst_no_done", {31'b0, done}, 32'd0);
                if (n == rst_at) begin
                    chk("rst_valid", {31'b0, out_valid}, 32'd0);
                    chk("rst_busy", {31'b0, busy}, 32'd0);
                    chk("rst_last_pos", {27'b0, last_pos}, 32'h1F);
                    exp_q.delete();
                end
                if (n == rst_at + 2) begin
                    seen = 1;
                    break;
                end
            end else if (done) begin
                chk("done_cycle", n, k_cnt + 2 + stall_cnt);
                chk("queue_empty", exp_q.size(), 0);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
            exp_q.delete();
        end else if (rst_at == 0) begin
            @(negedge clk);
            chk("done_pulse_end", {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [LW*N-1:0] v;
        logic [15:0]     r16;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_last", {31'b0, out_last}, 32'd0);
        chk("reset_tuple", {out_idx, out_run, out_level}, 32'd0);
        chk("reset_last_pos", {27'b0, last_pos}, 32'h1F);
        @(posedge clk); #1;
        rst = 1'b0;

        // All zero, nz=0.
        run_block('0, 1'b0, 1'b0, 0, 0, 0);

        // 5 @0, -3 @3, 1 @15.
        v = '0;
        v[0*LW +: LW]  = 16'sd5;
        v[3*LW +: LW]  = -16'sd3;
        v[15*LW +: LW] = 16'sd1;
        run_block(v, 1'b1, 1'b0, 0, 0, 0);

        // AC-only block whose only nonzero is DC.
        v = '0;
        v[0*LW +: LW] = 16'sd7;
        run_block(v, 1'b1, 1'b1, 0, 0, 0);

        // Backpressure on the second tuple for three cycles.
        v = '0;
        v[0*LW +: LW]  = 16'sd5;
        v[3*LW +: LW]  = -16'sd3;
        v[15*LW +: LW] = 16'sd1;
        run_block(v, 1'b1, 1'b0, 2, 0, 0);

        // Dense block of -1 with a start pulse that must be ignored.
        v = {N{16'hFFFF}};
        run_block(v, 1'b1, 1'b0, 0, 1, 0);

        // Reset mid-scan, then a clean rescan.
        v = '0;
        v[0*LW +: LW]  = 16'sd5;
        v[3*LW +: LW]  = -16'sd3;
        v[15*LW +: LW] = 16'sd1;
        run_block(v, 1'b1, 1'b0, 0, 0, 3);
        run_block(v, 1'b1, 1'b0, 0, 0, 0);

        // Randomized blocks.
        for (int b = 0; b < 40; b++) begin
            v = '0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) < ((b % 4 == 0) ? 8 : 3)) begin
                    r16 = 16'($urandom());
                    if ($urandom_range(0, 1) == 1) r16 = 16'($urandom_range(1, 40)) * (($urandom_range(0, 1) == 1) ? -16'sd1 : 16'sd1);
                    if (r16 == 0) r16 = 16'd1;
                    v[k*LW +: LW] = r16;
                end
            end
            run_block(v, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
